// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive-path controller.
//   state_t        : controller phases (word count, program load, run)
//   BYTES_PER_WORD : received bytes assembled into one instruction word
package uart_pkg;

    typedef enum logic [1:0] {
        S_LEN  = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Bus bundle of uart_rx_ctrl.
//   rx_data/rx_valid        : receiver byte stream (rx_valid is a one-cycle pulse)
//   imem_we/addr/wdata      : instruction-memory write port, one strobe per word
//   boot_done               : program loaded, sticky until reset
//   rd_req/rd_data/rd_ack   : core byte-read handshake
//   fifo_empty/overflow     : receive FIFO status
//   state                   : controller phase, for observation only
//
// Read handshake: the core raises rd_req and holds it until it sees rd_ack.
// rd_ack is a one-cycle pulse; rd_data is valid in that cycle. The core drops
// rd_req in the ack cycle, so one request yields exactly one byte.
interface uart_rx_ctrl_if #(
    parameter int ADDR_W = 14
) ();
    import uart_pkg::*;

    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              boot_done;
    logic              rd_req;
    logic [7:0]        rd_data;
    logic              rd_ack;
    logic              fifo_empty;
    logic              overflow;
    state_t            state;

    // Controller side
    modport slave (
        input  rx_data, rx_valid, rd_req,
        output imem_we, imem_addr, imem_wdata, boot_done,
               rd_data, rd_ack, fifo_empty, overflow, state
    );

    // Environment side (receiver + core + memory)
    modport master (
        output rx_data, rx_valid, rd_req,
        input  imem_we, imem_addr, imem_wdata, boot_done,
               rd_data, rd_ack, fifo_empty, overflow, state
    );

endinterface

// File: rtl/byte_fifo.sv
// Synchronous FIFO with registered read data.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write request and data; ignored when full unless pop is also set
//   pop        : read request; ignored when empty; dout updates next cycle
//   dout       : last popped entry
//   count      : entries held (0..DEPTH)
//   full       : count == DEPTH
//   empty      : registered, tracks count == 0
module byte_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_d;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count == (AW+1)'(DEPTH));
    // A full FIFO still accepts a write when a pop frees the slot this cycle;
    // the write lands on the slot being read, whose old value goes to dout.
    assign wr_en = push && (!full || rd_en);
    assign rd_en = pop && (count != '0);

    always_comb begin
        count_d = count;
        if (wr_en && !rd_en) begin
            count_d = count + (AW+1)'(1);
        end else if (!wr_en && rd_en) begin
            count_d = count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
            empty  <= 1'b1;
        end else begin
            count <= count_d;
            empty <= (count_d == '0);
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
                dout   <= mem[rd_ptr];
            end
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive-path sequencer: boot loader first, then byte FIFO for the core.
//   CLK, RSTN : system clock, asynchronous active-low reset
//   bus       : uart_rx_ctrl_if.slave (receiver stream, imem write port,
//               core read handshake, FIFO status, controller state)
// After reset, received bytes are packed big-endian into 32-bit words. The
// first word is the program length N; the next N words are written to
// instruction memory at addresses 0..N-1. Afterwards boot_done is raised and
// every received byte goes to the FIFO that the core drains.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 14
) (
    input  logic          CLK,
    input  logic          RSTN,
    uart_rx_ctrl_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    state_t            state_q;
    state_t            state_d;
    logic [1:0]        byte_cnt_q;
    logic [23:0]       shift_q;
    logic [31:0]       remaining_q;
    logic [ADDR_W-1:0] addr_q;
    logic              imem_we_q;
    logic [ADDR_W-1:0] imem_addr_q;
    logic [31:0]       imem_wdata_q;
    logic              boot_done_q;
    logic              rd_ack_q;
    logic              overflow_q;

    logic [31:0]       word;
    logic              word_done;
    logic              loading;
    logic              fifo_push;
    logic              fifo_pop;
    logic [7:0]        fifo_dout;
    logic [CW-1:0]     fifo_count;
    logic              fifo_full;
    logic              fifo_empty;

    // The incoming byte completes the word combinationally, so the word is
    // acted on in the same cycle its last byte arrives.
    assign loading   = (state_q != S_RUN);
    assign word      = {shift_q, bus.rx_data};
    assign word_done = loading && bus.rx_valid &&
                       (byte_cnt_q == 2'(BYTES_PER_WORD - 1));

    // ---------------- controller FSM ----------------
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= S_LEN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LEN: begin
                if (word_done) begin
                    state_d = (word == 32'd0) ? S_RUN : S_LOAD;
                end
            end
            S_LOAD: begin
                // remaining counts down to zero with this write
                if (word_done && (remaining_q == 32'd1)) begin
                    state_d = S_RUN;
                end
            end
            S_RUN:   state_d = S_RUN;
            default: state_d = S_LEN;
        endcase
    end

    // ---------------- word assembly and memory write ----------------
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            byte_cnt_q   <= '0;
            shift_q      <= '0;
            remaining_q  <= '0;
            addr_q       <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            boot_done_q  <= 1'b0;
        end else begin
            imem_we_q <= 1'b0;
            // Lags the state by a cycle so it rises after the last write.
            boot_done_q <= (state_q == S_RUN);
            if (loading && bus.rx_valid) begin
                byte_cnt_q <= byte_cnt_q + 2'd1;
                shift_q    <= {shift_q[15:0], bus.rx_data};
            end
            if (word_done) begin
                if (state_q == S_LEN) begin
                    remaining_q <= word;
                    addr_q      <= '0;
                end else begin
                    imem_we_q    <= 1'b1;
                    imem_addr_q  <= addr_q;
                    imem_wdata_q <= word;
                    addr_q       <= addr_q + ADDR_W'(1);
                    remaining_q  <= remaining_q - 32'd1;
                end
            end
        end
    end

    // ---------------- run-time FIFO ----------------
    // Pop uses the count before this cycle's push, so a byte arriving into an
    // empty FIFO is popped one cycle later. rd_ack blocks a second pop while
    // the core is still dropping its request.
    assign fifo_push = (state_q == S_RUN) && bus.rx_valid;
    assign fifo_pop  = (state_q == S_RUN) && bus.rd_req && !rd_ack_q &&
                       (fifo_count != '0);

    byte_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RSTN),
        .push  (fifo_push),
        .din   (bus.rx_data),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            rd_ack_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            rd_ack_q <= fifo_pop;
            if (fifo_push && fifo_full && !fifo_pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign bus.boot_done  = boot_done_q;
    assign bus.rd_data    = fifo_dout;
    assign bus.rd_ack     = rd_ack_q;
    assign bus.fifo_empty = fifo_empty;
    assign bus.overflow   = overflow_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
module tb_uart_rx_ctrl;
  import uart_pkg::*;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 14;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  initial forever #5 clk = ~clk;

  uart_rx_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  uart_rx_ctrl #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .CLK  (clk),
    .RSTN (rst_n),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 = waiting for length word, 1 = loading program, 2 = running
  int          m_mode  = 0;
  logic [7:0]  bb[$];
  longint      m_rem   = 0;
  int          m_wptr  = 0;
  logic        m_we    = 1'b0;
  logic [31:0] m_addr  = '0;
  logic [31:0] m_wdata = '0;
  logic        m_boot  = 1'b0;
  logic [7:0]  q[$];
  logic        m_ack   = 1'b0;
  logic [7:0]  m_rd    = '0;
  logic        m_ovf   = 1'b0;
  logic        m_empty = 1'b1;
  int          m_pushes = 0;
  logic [31:0] wlog_addr[$];
  logic [31:0] wlog_data[$];

  task model_reset();
    m_mode = 0; bb.delete(); m_rem = 0; m_wptr = 0;
    m_we = 0; m_addr = '0; m_wdata = '0; m_boot = 0;
    q.delete(); m_ack = 0; m_rd = '0; m_ovf = 0; m_empty = 1;
  endtask

  task model_step();
    int     old_mode;
    logic   pop;
    longint w;
    old_mode = m_mode;
    m_boot   = (old_mode == 2);
    m_we     = 1'b0;
    pop      = (old_mode == 2) && bus.rd_req && (q.size() > 0) && !m_ack;
    m_ack    = pop;
    if (pop) m_rd = q.pop_front();
    if (bus.rx_valid) begin
      if (old_mode == 2) begin
        if (q.size() == DEPTH) m_ovf = 1'b1;
        else begin
          q.push_back(bus.rx_data);
          m_pushes++;
        end
      end else begin
        bb.push_back(bus.rx_data);
        if (bb.size() == 4) begin
          w = 0;
          foreach (bb[i]) w = w * 256 + longint'(bb[i]);
          bb.delete();
          if (old_mode == 0) begin
            m_rem  = w;
            m_wptr = 0;
            m_mode = (w == 0) ? 2 : 1;
          end else begin
            m_we    = 1'b1;
            m_addr  = m_wptr;
            m_wdata = w[31:0];
            wlog_addr.push_back(m_wptr);
            wlog_data.push_back(w[31:0]);
            m_wptr  = (m_wptr + 1) % (1 << ADDR_W);
            m_rem   = m_rem - 1;
            if (m_rem == 0) m_mode = 2;
          end
        end
      end
    end
    m_empty = (q.size() == 0);
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) model_reset();
    else        model_step();
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    check("imem_we", bus.imem_we, m_we);
    if (m_we || !rst_n) begin
      check("imem_addr", bus.imem_addr, m_addr);
      check("imem_wdata", bus.imem_wdata, m_wdata);
    end
    check("boot_done", bus.boot_done, m_boot);
    check("rd_ack", bus.rd_ack, m_ack);
    if (m_ack || !rst_n) check("rd_data", bus.rd_data, m_rd);
    check("fifo_empty", bus.fifo_empty, m_empty);
    check("overflow", bus.overflow, m_ovf);
    check("state", bus.state, m_mode);
  end

  // ---------------- driver tasks ----------------
  task do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rd_req   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], $urandom_range(0, 2));
  endtask

  task read_byte(output logic [7:0] d);
    bit ok;
    ok = 0;
    d  = '0;
    @(negedge clk);
    bus.rd_req = 1'b1;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (bus.rd_ack) begin
        d  = bus.rd_data;
        ok = 1;
        bus.rd_req = 1'b0;
      end
    end
    if (!ok) begin
      bus.rd_req = 1'b0;
      total++;
      bad++;
      $display("FAIL read_timeout: got no rd_ack want rd_ack within 60 cycles");
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    bad++;
    $display("FAIL watchdog: got no completion want completion before time limit");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] d;
    logic [7:0] fill[16];
    logic [7:0] nb;
    int         k;
    bit         got;
    int         nwords;

    bus.rx_data  = '0;
    bus.rx_valid = 1'b0;
    bus.rd_req   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_boot_done", bus.boot_done, 0);
    check("rst_fifo_empty", bus.fifo_empty, 1);
    rst_n = 1'b1;

    // 1. two-word boot
    wlog_addr.delete(); wlog_data.delete(); m_pushes = 0;
    send_word(32'h0000_0002);
    send_word(32'hDEAD_BEEF);
    send_word(32'h0123_4567);
    repeat (3) @(negedge clk);
    check("t1_nwrites", wlog_addr.size(), 2);
    if (wlog_addr.size() == 2) begin
      check("t1_addr0", wlog_addr[0], 0);
      check("t1_data0", wlog_data[0], 32'hDEAD_BEEF);
      check("t1_addr1", wlog_addr[1], 1);
      check("t1_data1", wlog_data[1], 32'h0123_4567);
    end
    check("t1_boot_done", bus.boot_done, 1);
    check("t1_no_push", m_pushes, 0);

    // 2. zero-length boot, then one byte through the FIFO
    do_reset();
    wlog_addr.delete(); wlog_data.delete();
    send_word(32'h0);
    repeat (3) @(negedge clk);
    check("t2_boot_done", bus.boot_done, 1);
    check("t2_nwrites", wlog_addr.size(), 0);
    send_byte(8'h41, 0);
    check("t2_not_empty", bus.fifo_empty, 0);
    read_byte(d);
    check("t2_rd_data", d, 8'h41);

    // 3. request held on empty FIFO
    @(negedge clk);
    bus.rd_req = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("t3_no_early_ack", bus.rd_ack, 0);
    end
    @(negedge clk);
    bus.rx_data  = 8'h5A;
    bus.rx_valid = 1'b1;
    k = 0; got = 0;
    while (k < 10 && !got) begin
      @(negedge clk);
      bus.rx_valid = 1'b0;
      k++;
      if (bus.rd_ack) begin
        got = 1;
        d   = bus.rd_data;
      end
    end
    bus.rd_req = 1'b0;
    check("t3_ack_latency", k, 2);
    check("t3_rd_data", d, 8'h5A);

    // 4. overflow with DEPTH+1 pushes
    for (int i = 0; i <= DEPTH; i++) send_byte(8'(i), 0);
    repeat (2) @(negedge clk);
    check("t4_overflow", bus.overflow, 1);
    for (int i = 0; i < DEPTH; i++) begin
      read_byte(d);
      check("t4_order", d, i);
    end
    repeat (2) @(negedge clk);
    check("t4_empty_after", bus.fifo_empty, 1);

    // 5. full FIFO with push and pop in the same cycle
    do_reset();
    send_word(32'h0);
    repeat (3) @(negedge clk);
    for (int i = 0; i < DEPTH; i++) begin
      fill[i] = 8'($urandom);
      send_byte(fill[i], 0);
    end
    nb = 8'($urandom);
    @(negedge clk);
    bus.rd_req   = 1'b1;
    bus.rx_data  = nb;
    bus.rx_valid = 1'b1;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      bus.rx_valid = 1'b0;
      if (bus.rd_ack) begin
        got = 1;
        d   = bus.rd_data;
        bus.rd_req = 1'b0;
      end
    end
    bus.rd_req = 1'b0;
    check("t5_got_ack", got, 1);
    check("t5_first", d, fill[0]);
    check("t5_model_count", q.size(), DEPTH);
    check("t5_no_overflow", bus.overflow, 0);
    for (int i = 1; i < DEPTH; i++) begin
      read_byte(d);
      check("t5_order", d, fill[i]);
    end
    read_byte(d);
    check("t5_last_is_new", d, nb);

    // 6. reset in the middle of a load
    do_reset();
    send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    send_byte(8'h03, 0); send_byte(8'hAA, 0); send_byte(8'hBB, 0);
    @(negedge clk);
    #3 rst_n = 1'b0;
    @(negedge clk);
    check("t6_rst_we", bus.imem_we, 0);
    check("t6_rst_boot", bus.boot_done, 0);
    check("t6_rst_ack", bus.rd_ack, 0);
    check("t6_rst_ovf", bus.overflow, 0);
    check("t6_rst_empty", bus.fifo_empty, 1);
    check("t6_rst_state", bus.state, 0);
    rst_n = 1'b1;
    wlog_addr.delete(); wlog_data.delete();
    send_word(32'h0000_0001);
    send_word(32'hCAFE_BABE);
    repeat (3) @(negedge clk);
    check("t6_nwrites", wlog_addr.size(), 1);
    if (wlog_addr.size() == 1) begin
      check("t6_addr0", wlog_addr[0], 0);
      check("t6_data0", wlog_data[0], 32'hCAFE_BABE);
    end
    check("t6_boot_done", bus.boot_done, 1);

    // 7. random boot and random run traffic against the model
    do_reset();
    nwords = $urandom_range(1, 4);
    send_word(32'(nwords));
    for (int i = 0; i < nwords; i++) send_word($urandom);
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      if (bus.rx_valid) bus.rx_valid = 1'b0;
      else if ($urandom_range(0, (c < 400) ? 1 : 4) == 0) begin
        bus.rx_data  = 8'($urandom);
        bus.rx_valid = 1'b1;
      end
      if (bus.rd_req && bus.rd_ack) bus.rd_req = 1'b0;
      else if (!bus.rd_req && $urandom_range(0, (c < 400) ? 6 : 1) == 0) bus.rd_req = 1'b1;
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.rd_req   = 1'b0;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
